// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared constants and FSM encoding for the 16/8 sequential restoring divider.
//   DIVIDEND_WIDTH : dividend / quotient width
//   DIVISOR_WIDTH  : divisor / remainder width
//   REM_WIDTH      : partial-remainder width (one guard bit above the divisor)
//   STEP_COUNT     : restoring steps per division (one per dividend bit)
//   CNT_WIDTH      : step counter width
//   state_e        : IDLE / RUN / DONE encoding
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package divider_pkg;

    localparam int DIVIDEND_WIDTH = 16;
    localparam int DIVISOR_WIDTH  = 8;
    localparam int REM_WIDTH      = 9;
    localparam int STEP_COUNT     = 16;
    localparam int CNT_WIDTH      = 5;

    // Counter value seen during the final restoring step.
    localparam logic [CNT_WIDTH-1:0] LAST_STEP = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : divider_pkg

// File: rtl/seq_divider_16x8_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_i     : current 9-bit partial remainder (always < divisor_i)
//   divisor_i : 8-bit divisor
//   bit_i     : next dividend bit, MSB first
//   rem_o     : partial remainder after this step
//   q_bit_o   : quotient bit produced by this step
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module div_step
    import divider_pkg::*;
(
    input  logic [REM_WIDTH-1:0]     rem_i,
    input  logic [DIVISOR_WIDTH-1:0] divisor_i,
    input  logic                     bit_i,
    output logic [REM_WIDTH-1:0]     rem_o,
    output logic                     q_bit_o
);

    logic [REM_WIDTH-1:0] shifted_s;
    logic [REM_WIDTH-1:0] diff_s;
    logic                 take_s;

    // Shift in the dividend bit, trial-subtract the divisor, keep or restore.
    always_comb begin
        shifted_s = {rem_i[REM_WIDTH-2:0], bit_i};
        diff_s    = shifted_s - {1'b0, divisor_i};
        // With rem_i < divisor the shifted value is < 2*divisor, so the 9-bit
        // difference is exact.  A set shifted MSB means the value is >= 256,
        // which already exceeds any divisor; otherwise the difference's MSB is
        // its sign.  A set rem_i MSB cannot occur for a legal remainder and is
        // treated as "subtract" so a corrupted value still converges.
        take_s = rem_i[REM_WIDTH-1] | shifted_s[REM_WIDTH-1] | ~diff_s[REM_WIDTH-1];
        if (take_s) begin
            rem_o   = diff_s;
            q_bit_o = 1'b1;
        end else begin
            rem_o   = shifted_s;
            q_bit_o = 1'b0;
        end
    end

endmodule : div_step

// File: rtl/seq_divider_16x8.sv
// -----------------------------------------------------------------------------
// seq_divider_16x8
// Sequential unsigned 16-bit / 8-bit restoring divider, one quotient bit per
// clock, MSB first.  Division by zero completes immediately with a flag.
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   start       : request, sampled only in IDLE
//   dividend    : unsigned dividend, captured on an accepted start
//   divisor     : unsigned divisor, captured on an accepted start
//   busy        : high while the 16 restoring steps run
//   done        : one-cycle pulse, results valid
//   quotient    : floor(dividend / divisor), or all ones on divide by zero
//   remainder   : dividend mod divisor, or dividend[7:0] on divide by zero
//   div_by_zero : set with the results when the captured divisor was zero
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_divider_16x8
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    state_e                      state_q;
    logic [DIVIDEND_WIDTH-1:0]   a_q;        // dividend bits shift out, quotient bits shift in
    logic [DIVISOR_WIDTH-1:0]    b_q;
    logic [REM_WIDTH-1:0]        rem_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic                        busy_q;
    logic                        done_q;
    logic [DIVIDEND_WIDTH-1:0]   quotient_q;
    logic [DIVISOR_WIDTH-1:0]    remainder_q;
    logic                        dbz_q;

    logic [REM_WIDTH-1:0]        rem_d;
    logic                        q_bit_d;
    logic [DIVIDEND_WIDTH-1:0]   a_d;

    div_step u_div_step (
        .rem_i     (rem_q),
        .divisor_i (b_q),
        .bit_i     (a_q[DIVIDEND_WIDTH-1]),
        .rem_o     (rem_d),
        .q_bit_o   (q_bit_d)
    );

    // After 16 shifts the dividend register holds the complete quotient.
    assign a_d = {a_q[DIVIDEND_WIDTH-2:0], q_bit_d};

    // Control FSM with the iteration datapath and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= 16'd0;
            b_q         <= 8'd0;
            rem_q       <= 9'd0;
            cnt_q       <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= 16'd0;
            remainder_q <= 8'd0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == 8'd0) begin
                            // No iteration needed: publish the flagged result now.
                            quotient_q  <= 16'hFFFF;
                            remainder_q <= dividend[DIVISOR_WIDTH-1:0];
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            a_q     <= dividend;
                            b_q     <= divisor;
                            rem_q   <= 9'd0;
                            cnt_q   <= 5'd0;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_STEP) begin
                        // Final step: the visible outputs change only here.
                        quotient_q  <= a_d;
                        remainder_q <= rem_d[DIVISOR_WIDTH-1:0];
                        dbz_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule : seq_divider_16x8

// File: tb/tb_seq_divider_16x8.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_16x8
// Directed and random stimulus for seq_divider_16x8 with hand-computed results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seq_divider_16x8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    // Results the DUT should currently be holding (from the last completed op).
    logic [15:0] prev_q;
    logic [7:0]  prev_r;

    always #5 clk = ~clk;

    seq_divider_16x8 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Team 8x8 multiplier model: plain shift-and-add.
    function automatic logic [15:0] mul8x8(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] acc;
        acc = 16'd0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) acc = acc + ({8'd0, x} << i);
        end
        return acc;
    endfunction

    // Pulse start for one edge, wait for done, check timing and results.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                           input logic [15:0] eq, input logic [7:0] er, input logic ez,
                           input int exp_lat);
        int lat;
        int busy_cnt;
        int hold_bad;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat = 0; busy_cnt = 0; hold_bad = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (quotient !== prev_q || remainder !== prev_r) hold_bad++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, busy_cnt, exp_lat);
        check({tag, "_hold"}, hold_bad, 0);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_z"}, div_by_zero, ez);
        @(posedge clk); #1;
        check({tag, "_pulse"}, done, 1'b0);
        check({tag, "_keep"}, quotient, eq);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        int lat;
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [23:0] recon;

        rst = 1'b0; start = 1'b0; dividend = 16'd0; divisor = 8'd0;
        prev_q = 16'd0; prev_r = 8'd0;
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q", quotient, 16'd0);
        check("rst_r", remainder, 8'd0);
        check("rst_z", div_by_zero, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed vectors.
        run_div("d100_7",    16'd100,   8'd7,   16'd14,    8'd2,   1'b0, 16);
        run_div("d65535_1",  16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 16);
        run_div("d65535_255",16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 16);
        run_div("d5_200",    16'd5,     8'd200, 16'd0,     8'd5,   1'b0, 16);
        run_div("d1000_0",   16'd1000,  8'd0,   16'hFFFF,  8'hE8,  1'b1, 0);
        run_div("d0_3",      16'd0,     8'd3,   16'd0,     8'd0,   1'b0, 16);

        // Second start while running must be ignored.
        dividend = 16'd300; divisor = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk); #1;
        dividend = 16'd1; divisor = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("restart_lat", lat, 16);
        check("restart_q", quotient, 16'd33);
        check("restart_r", remainder, 8'd3);
        @(posedge clk); #1;
        prev_q = 16'd33; prev_r = 8'd3;

        // Reset in the middle of a division.
        dividend = 16'd1234; divisor = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_q", quotient, 16'd0);
        check("mid_rst_r", remainder, 8'd0);
        check("mid_rst_z", div_by_zero, 1'b0);
        @(posedge clk); #1;
        check("mid_rst_hold_done", done, 1'b0);
        @(negedge clk) rst = 1'b0;
        prev_q = 16'd0; prev_r = 8'd0;
        run_div("d255_16",   16'd255,   8'd16,  16'd15,    8'd15,  1'b0, 16);

        // Random regression: results checked through the multiplier identity.
        for (int n = 0; n < 2500; n++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(1, 255));
            run_div("rnd", ra, rb, ra / {8'd0, rb}, 8'(ra % {8'd0, rb}), 1'b0, 16);
            recon = {8'd0, mul8x8(quotient[7:0], rb)} + {mul8x8(quotient[15:8], rb), 8'd0}
                  + {16'd0, remainder};
            check("rnd_identity", recon, {8'd0, ra});
            check("rnd_rem_lt_b", remainder < rb, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_divider_16x8
